// File: rtl/pmcc_sequencer.sv
// PMC coprocessor program sequencer: fetches 32-bit words from code RAM and executes
// STORE, STOREB, LOOP, JUMP and WAITT, driving the 24-bit pixel-matrix control word.
//
// state | meaning
// IDLE  | not running, waiting for start
// FETCH | code RAM read issued at pc
// EXEC  | instruction word on code_rdata, acted on this cycle
// WAIT  | WAITT stall, wait_cnt counts down to 1
// HOLD  | STOREB issued, waiting for trig
module pmcc_sequencer #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  trig,
    output logic                  code_req,
    output logic [ADDR_WIDTH-1:0] code_addr,
    input  logic [31:0]           code_rdata,
    output logic [23:0]           out_data,
    output logic                  out_we,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WAIT  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;
    localparam logic [23:0] M_HALT = 24'hFFFFFF;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [23:0]           out_data_q, out_data_d;
    logic                  loop_active_q, loop_active_d;
    logic [7:0]            loop_cnt_q, loop_cnt_d;
    logic [23:0]           wait_cnt_q, wait_cnt_d;

    logic [2:0]            opcode;
    logic                  is_store, is_storeb, is_loop, is_jump, is_waitt;
    logic [ADDR_WIDTH-1:0] tgt, pc_inc;
    logic [7:0]            loop_n;
    logic [23:0]           arg24;
    logic                  unused_instr_bits;

    assign opcode    = code_rdata[7:5];
    assign is_store  = (opcode[2:1] == 2'b11);
    assign is_storeb = (opcode[2:1] == 2'b10);
    assign is_loop   = (opcode[2:1] == 2'b01);
    assign is_jump   = (opcode == 3'b001);
    assign is_waitt  = (opcode == 3'b000);
    assign tgt       = code_rdata[8 +: ADDR_WIDTH];
    assign loop_n    = code_rdata[31:24];
    assign arg24     = code_rdata[31:8];
    assign pc_inc    = pc_q + PC_ONE;
    assign unused_instr_bits = ^code_rdata[4:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            out_data_q    <= '0;
            loop_active_q <= 1'b0;
            loop_cnt_q    <= '0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_data_q    <= out_data_d;
            loop_active_q <= loop_active_d;
            loop_cnt_q    <= loop_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_data_d    = out_data_q;
        loop_active_d = loop_active_q;
        loop_cnt_d    = loop_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        if (stop) begin
            // abort wins over start, trig and any store or halt in flight
            state_d       = S_IDLE;
            loop_active_d = 1'b0;
            wait_cnt_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_d    = start_addr;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_EXEC;
                S_EXEC: begin
                    state_d = S_FETCH;
                    if (is_store || is_storeb) begin
                        out_data_d = arg24;
                        pc_d       = pc_inc;
                        if (is_storeb) state_d = S_HOLD;
                    end else if (is_loop) begin
                        if (!loop_active_q) begin
                            if (loop_n <= 8'd1) begin
                                pc_d = pc_inc;
                            end else begin
                                loop_cnt_d    = loop_n - 8'd1;
                                loop_active_d = 1'b1;
                                pc_d          = tgt;
                            end
                        end else if (loop_cnt_q == 8'd1) begin
                            loop_active_d = 1'b0;
                            pc_d          = pc_inc;
                        end else begin
                            loop_cnt_d = loop_cnt_q - 8'd1;
                            pc_d       = tgt;
                        end
                    end else if (is_jump) begin
                        pc_d = tgt;
                    end else if (is_waitt) begin
                        if (arg24 == M_HALT) begin
                            state_d = S_IDLE;
                        end else if (arg24 == 24'd0) begin
                            pc_d = pc_inc;
                        end else begin
                            wait_cnt_d = arg24;
                            state_d    = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q <= 24'd1) begin
                        wait_cnt_d = '0;
                        pc_d       = pc_inc;
                        state_d    = S_FETCH;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 24'd1;
                    end
                end
                S_HOLD: begin
                    if (trig) state_d = S_FETCH;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        code_req  = (state_q == S_FETCH);
        code_addr = pc_q;
        busy      = (state_q != S_IDLE);
        out_we    = (state_q == S_EXEC) && !stop && (is_store || is_storeb);
        done      = (state_q == S_EXEC) && !stop && is_waitt && (arg24 == M_HALT);
        out_data  = out_data_d;
        pc        = pc_q;
    end

endmodule

// File: tb/tb_pmcc_sequencer.sv
// Directed bench for pmcc_sequencer: a table of short programs run to HALT, plus
// hand-written sequences for HOLD, stop and mid-loop reset.
module tb_pmcc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [5:0]  start_addr;
    logic        trig;
    logic        code_req;
    logic [5:0]  code_addr;
    logic [31:0] code_rdata = '0;
    logic [23:0] out_data;
    logic        out_we;
    logic        busy;
    logic        done;
    logic [5:0]  pc;

    logic [31:0] mem [64];
    int pass_cnt = 0;
    int total_cnt = 0;

    pmcc_sequencer #(.ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .start_addr(start_addr),
        .trig(trig), .code_req(code_req), .code_addr(code_addr), .code_rdata(code_rdata),
        .out_data(out_data), .out_we(out_we), .busy(busy), .done(done), .pc(pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (code_req) code_rdata <= mem[code_addr];
    end

    function automatic logic [31:0] i_store(input logic [23:0] d);
        return {d, 8'hC0};
    endfunction
    function automatic logic [31:0] i_storeb(input logic [23:0] d);
        return {d, 8'h80};
    endfunction
    function automatic logic [31:0] i_loop(input logic [7:0] n, input logic [5:0] t);
        return {n, 10'b0, t, 8'h40};
    endfunction
    function automatic logic [31:0] i_jump(input logic [5:0] t);
        return {18'b0, t, 8'h20};
    endfunction
    function automatic logic [31:0] i_waitt(input logic [23:0] m);
        return {m, 8'h00};
    endfunction

    localparam logic [31:0] HALT = 32'hFFFFFF00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic load(input logic [5:0] s, input logic [3:0][31:0] prog);
        for (int a = 0; a < 64; a++) mem[a] = HALT;
        for (int k = 0; k < 4; k++) mem[6'(s + 6'(k))] = prog[k];
    endtask

    task automatic start_prog(input logic [5:0] s);
        @(negedge clk);
        start_addr = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Runs from the cycle after start until done; cycle 0 is the start cycle.
    task automatic run_prog(input logic [5:0] s, output int we_cnt, output logic [23:0] last,
                            output logic [5:0] pc_done, output int dcyc);
        int cyc;
        we_cnt = 0; last = out_data; pc_done = '0; dcyc = -1;
        @(negedge clk);
        start_addr = s;
        start = 1'b1;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (out_we) begin we_cnt++; last = out_data; end
            if (done) begin pc_done = pc; dcyc = cyc; break; end
        end
        if (dcyc < 0) chk("run_timeout", 64'(cyc), 64'(0));
    endtask

    task automatic wait_done(input int limit, output int we_cnt, output bit ok);
        we_cnt = 0; ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (out_we) we_cnt++;
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    typedef struct {
        logic [5:0]        s;
        logic [3:0][31:0]  prog;
        bit                trig_lvl;
        int                we;
        logic [23:0]       data;
        logic [5:0]        pcd;
        int                dcyc;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int we_cnt, dcyc;
        logic [23:0] last, prev;
        logic [5:0] pcd;
        bit ok;
        bit hold_ok;

        vecs[0] = '{6'd0,  {HALT, HALT, HALT, i_store(24'hABCDEF)}, 1'b0, 1, 24'hABCDEF, 6'd1, 4};
        vecs[1] = '{6'd0,  {HALT, HALT, i_store(24'h123456), i_waitt(24'd5)}, 1'b0, 1, 24'h123456, 6'd2, 11};
        vecs[2] = '{6'd0,  {HALT, HALT, i_loop(8'd3, 6'd0), i_store(24'h000011)}, 1'b0, 3, 24'h000011, 6'd2, 14};
        vecs[3] = '{6'd0,  {HALT, HALT, i_loop(8'd0, 6'd0), i_store(24'h000022)}, 1'b0, 1, 24'h000022, 6'd2, 6};
        vecs[4] = '{6'd0,  {HALT, HALT, i_loop(8'd1, 6'd0), i_store(24'h000033)}, 1'b0, 1, 24'h000033, 6'd2, 6};
        vecs[5] = '{6'd61, {HALT, i_store(24'h777777), i_store(24'h000BAD), i_jump(6'd63)}, 1'b0, 1, 24'h777777, 6'd0, 6};
        vecs[6] = '{6'd5,  {HALT, HALT, i_store(24'h0000AA), i_waitt(24'd0)}, 1'b0, 1, 24'h0000AA, 6'd7, 6};
        vecs[7] = '{6'd8,  {HALT, HALT, HALT, i_storeb(24'h0C0C0C)}, 1'b1, 1, 24'h0C0C0C, 6'd9, 5};
        vecs[8] = '{6'd12, {HALT, HALT, HALT, i_waitt(24'd1)}, 1'b0, 0, 24'h0C0C0C, 6'd13, 5};
        vecs[9] = '{6'd30, {HALT, i_waitt(24'd2), i_storeb(24'h222222), i_store(24'h111111)}, 1'b1, 2, 24'h222222, 6'd33, 11};

        for (int a = 0; a < 64; a++) mem[a] = HALT;
        rst = 1'b1; start = 1'b0; stop = 1'b0; trig = 1'b0; start_addr = '0;
        step(2);
        chk("reset_outputs", {busy, out_we, done, code_req, pc, out_data}, '0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("idle_after_reset", {busy, out_we, done, code_req, pc, out_data}, '0);

        for (int v = 0; v < 10; v++) begin
            load(vecs[v].s, vecs[v].prog);
            trig = vecs[v].trig_lvl;
            run_prog(vecs[v].s, we_cnt, last, pcd, dcyc);
            trig = 1'b0;
            chk($sformatf("v%0d_we_count", v), 64'(we_cnt), 64'(vecs[v].we));
            chk($sformatf("v%0d_out_data", v), 64'(last), 64'(vecs[v].data));
            chk($sformatf("v%0d_pc_at_done", v), 64'(pcd), 64'(vecs[v].pcd));
            chk($sformatf("v%0d_done_cycle", v), 64'(dcyc), 64'(vecs[v].dcyc));
            step(1);
            chk($sformatf("v%0d_idle_after", v), {busy, out_we, done}, 3'b000);
        end

        // STOREB held with trig low, start while busy ignored, then release
        load(6'd20, {HALT, HALT, i_store(24'h001234), i_storeb(24'h00ABCD)});
        start_prog(6'd20);
        step(1);
        chk("storeb_we", {out_we, out_data}, {1'b1, 24'h00ABCD});
        hold_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (c == 4) begin start_addr = 6'd0; start = 1'b1; end
            if (c == 5) start = 1'b0;
            if (!(busy && !code_req && !out_we && pc == 6'd21)) hold_ok = 1'b0;
        end
        chk("hold_stays", 64'(hold_ok), 64'(1));
        trig = 1'b1;
        step(1);
        trig = 1'b0;
        chk("hold_release_fetch", {code_req, code_addr}, {1'b1, 6'd21});
        wait_done(20, we_cnt, ok);
        chk("hold_done_seen", 64'(ok), 64'(1));
        chk("hold_we_after", 64'(we_cnt), 64'(1));
        chk("hold_final_data", 64'(out_data), 64'(24'h001234));

        // stop during WAIT, with a competing start in the same cycle
        load(6'd40, {HALT, HALT, i_store(24'h0DEAD0), i_waitt(24'd20)});
        start_prog(6'd40);
        step(3);
        chk("in_wait_busy", 64'(busy), 64'(1));
        stop = 1'b1; start = 1'b1; start_addr = 6'd5;
        #1;
        chk("stop_wait_no_strobe", {out_we, done}, 2'b00);
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        chk("stop_wait_idle", {busy, pc}, {1'b0, 6'd40});
        wait_done(25, we_cnt, ok);
        chk("stop_wait_quiet", {64'(we_cnt), 1'b0, ok}, '0);

        // stop during HOLD with trig high in the same cycle
        load(6'd50, {HALT, HALT, i_store(24'h0000FF), i_storeb(24'h00BEEF)});
        start_prog(6'd50);
        step(2);
        stop = 1'b1; trig = 1'b1;
        #1;
        chk("stop_hold_no_strobe", {out_we, done}, 2'b00);
        @(negedge clk);
        stop = 1'b0; trig = 1'b0;
        chk("stop_hold_idle", {busy, code_req, pc}, {2'b00, 6'd51});

        // stop in the EXEC cycle of a STORE suppresses the store
        prev = out_data;
        load(6'd44, {HALT, HALT, HALT, i_store(24'h0FACE0)});
        start_prog(6'd44);
        step(1);
        stop = 1'b1;
        #1;
        chk("stop_exec_no_we", {out_we, out_data}, {1'b0, prev});
        @(negedge clk);
        stop = 1'b0;
        chk("stop_exec_hold_data", {busy, out_data}, {1'b0, prev});

        // async reset mid-loop, then a fresh run must execute the full count
        load(6'd0, {HALT, HALT, i_loop(8'd4, 6'd0), i_store(24'h000055)});
        start_prog(6'd0);
        step(5);
        rst = 1'b1;
        #1;
        chk("rst_mid_loop", {busy, out_we, done, code_req, pc, out_data}, '0);
        @(negedge clk);
        rst = 1'b0;
        run_prog(6'd0, we_cnt, last, pcd, dcyc);
        chk("loop_after_rst_we", 64'(we_cnt), 64'(4));
        chk("loop_after_rst_cycle", 64'(dcyc), 64'(18));
        chk("loop_after_rst_pc", 64'(pcd), 64'(2));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
